// File: rtl/hpf_selftrigger_readout_scheduler.sv
// Self-trigger readout scheduler: captures per-channel trigger edges with a
// timestamp, arbitrates pending channels round-robin toward a shared record
// writer, and enforces a per-channel holdoff after each grant.
module hpf_selftrigger_readout_scheduler #(
    parameter int unsigned NCH  = 8,
    parameter int unsigned TS_W = 64,
    parameter int unsigned HO_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NCH-1:0]         trig_in,
    input  logic [TS_W-1:0]        timestamp,
    input  logic [HO_W-1:0]        holdoff,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [$clog2(NCH)-1:0] wr_chan,
    output logic [TS_W-1:0]        wr_ts,
    input  logic                   wr_done,
    output logic [NCH-1:0]         pending,
    output logic [15:0]            drop_count
);

    localparam int unsigned CH_W = $clog2(NCH);
    localparam int unsigned DN_W = $clog2(NCH + 1);

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    state_t          state;
    logic [NCH-1:0]  trig_d;
    logic [NCH-1:0]  capture;
    logic [NCH-1:0]  drop;
    logic [TS_W-1:0] ts_lat      [NCH];
    logic [HO_W-1:0] holdoff_cnt [NCH];
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] sel_chan;
    logic [CH_W-1:0] idx;
    logic            sel_found;
    logic            grant;
    logic [HO_W-1:0] hold_eff;
    logic            pend_eff;
    logic [DN_W-1:0] drop_num;
    logic [16:0]     drop_sum;

    // Writer accepted the current request this cycle.
    assign grant = (state == REQ) && wr_ready;

    // Edge classification; the granted channel already sees its freshly loaded holdoff and cleared pending.
    always_comb begin
        capture  = '0;
        drop     = '0;
        hold_eff = '0;
        pend_eff = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            hold_eff   = (grant && (wr_chan == CH_W'(i))) ? holdoff : holdoff_cnt[i];
            pend_eff   = pending[i] && !(grant && (wr_chan == CH_W'(i)));
            capture[i] = trig_in[i] && !trig_d[i] && enable && !pend_eff && (hold_eff == '0);
            drop[i]    = trig_in[i] && !trig_d[i] && enable && pend_eff;
        end
    end

    // Number of edges lost this cycle and the unsaturated running total.
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            drop_num = drop_num + DN_W'(drop[i]);
        end
        drop_sum = 17'(drop_count) + 17'(drop_num);
    end

    // Round-robin pick: lowest offset from rr_ptr wins, so scan offsets downward.
    always_comb begin
        sel_found = 1'b0;
        sel_chan  = '0;
        idx       = '0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            idx = rr_ptr + CH_W'(k);
            if (pending[idx]) begin
                sel_found = 1'b1;
                sel_chan  = idx;
            end
        end
    end

    // Per-channel edge history, pending flags, timestamp latches and holdoff counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_d  <= '0;
            pending <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                ts_lat[i]      <= '0;
                holdoff_cnt[i] <= '0;
            end
        end else begin
            trig_d <= trig_in;
            for (int i = 0; i < int'(NCH); i++) begin
                if (grant && (wr_chan == CH_W'(i))) begin
                    pending[i]     <= capture[i];
                    holdoff_cnt[i] <= holdoff;
                end else begin
                    if (capture[i]) begin
                        pending[i] <= 1'b1;
                    end
                    if (holdoff_cnt[i] != '0) begin
                        holdoff_cnt[i] <= holdoff_cnt[i] - HO_W'(1);
                    end
                end
                if (capture[i]) begin
                    ts_lat[i] <= timestamp;
                end
            end
        end
    end

    // Saturating count of triggers lost to already-pending channels.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop_sum[16]) begin
            drop_count <= 16'hFFFF;
        end else begin
            drop_count <= drop_sum[15:0];
        end
    end

    // Request handshake FSM with registered writer-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_valid <= 1'b0;
            wr_chan  <= '0;
            wr_ts    <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        wr_chan  <= sel_chan;
                        wr_ts    <= ts_lat[sel_chan];
                        wr_valid <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        rr_ptr   <= wr_chan + CH_W'(1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (wr_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hpf_selftrigger_readout_scheduler.md
HPF_SELFTRIGGER_READOUT_SCHEDULER -- requirements
Module: hpf_selftrigger_readout_scheduler

Interface
REQ-001 The block SHALL have parameter NCH, default 8, number of self-trigger channels arbitrated (power of two, 2..16).
REQ-002 The block SHALL have parameter TS_W, default 64, timestamp width.
REQ-003 The block SHALL have parameter HO_W, default 16, holdoff counter width.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port enable  input  1  when high, new triggers may be captured.
REQ-007 The block SHALL have port trig_in  input  NCH  per-channel trigger_output from the filter/trigger chains.
REQ-008 The block SHALL have port timestamp  input  TS_W  free-running timestamp.
REQ-009 The block SHALL have port holdoff  input  HO_W  per-channel dead time in cycles after a grant.
REQ-010 The block SHALL have port wr_valid  output  1  record request to the shared record writer.
REQ-011 The block SHALL have port wr_ready  input  1  writer accepts the request.
REQ-012 The block SHALL have port wr_chan  output  log2(NCH)  granted channel.
REQ-013 The block SHALL have port wr_ts  output  TS_W  timestamp captured at the granted trigger edge.
REQ-014 The block SHALL have port wr_done  input  1  one-cycle pulse: writer finished the record.
REQ-015 The block SHALL have port pending  output  NCH  per-channel pending flags.
REQ-016 The block SHALL have port drop_count  output  16  saturating count of triggers lost to an already-pending channel.

Function
REQ-017 Edge detect: edge[i] = trig_in[i] & ~trig_d[i], with trig_d registered each cycle; a level held high yields one edge.
REQ-018 Capture: on edge[i] with enable=1, pending[i]=0 and holdoff_cnt[i]=0, pending[i] and ts_lat[i]<=timestamp SHALL be set at the end of that cycle.
REQ-019 On edge[i] with enable=1 and pending[i]=1, the edge SHALL be dropped and drop_count incremented, saturating at 0xFFFF; ts_lat[i] is unchanged.
REQ-020 On edge[i] with holdoff_cnt[i]!=0, or with enable=0, the edge SHALL be ignored silently, with no count.
REQ-021 FSM states SHALL be IDLE, REQ and BUSY.
REQ-022 In IDLE with any pending bit set, the FSM SHALL select a channel round-robin starting from rr_ptr, register wr_chan/wr_ts, assert wr_valid, and go to REQ.
REQ-023 In REQ, wr_valid, wr_chan and wr_ts SHALL be held stable until wr_ready=1.
REQ-024 In the wr_ready cycle, pending[chan] SHALL clear, holdoff_cnt[chan]<=holdoff, rr_ptr<=(chan+1) mod NCH, wr_valid deasserts next cycle, and the FSM goes to BUSY.
REQ-025 In BUSY, wr_done=1 SHALL return the FSM to IDLE; wr_done in IDLE/REQ SHALL be ignored.
REQ-026 Latency: edge sampled in cycle t -> pending at t+1 -> wr_valid at t+2 when the FSM is in IDLE.
REQ-027 Holdoff counters SHALL decrement by 1 per cycle while nonzero, independent of enable; holdoff=0 means no dead time.
REQ-028 An edge on channel i in its own wr_ready cycle SHALL see the newly loaded holdoff_cnt: it is ignored if holdoff>0, and becomes pending again if holdoff=0.
REQ-029 Simultaneous edges on multiple channels SHALL all be captured in the same cycle.
REQ-030 enable=0 SHALL block only new captures; existing pending flags and an in-flight transaction complete normally.

Reset
REQ-031 reset=1 SHALL force FSM=IDLE, wr_valid=0, wr_chan=0, wr_ts=0, pending=0, drop_count=0, rr_ptr=0, all holdoff_cnt=0, trig_d=0, ts_lat=0 on the next edge, including mid-transaction; wr_done after reset SHALL be ignored.

Verification
REQ-033 Single: holdoff=0, edge ch3 at ts=100 -> wr_valid two cycles later, wr_chan=3, wr_ts=100; wr_ready -> pending[3]=0; wr_done -> IDLE.
REQ-034 Round-robin: edges ch1, ch2, ch5 same cycle (ts=50), wr_ready tied high, wr_done one cycle after each accept -> grants 1, 2, 5 all with wr_ts=50; next lone ch0 trigger granted after ch5.
REQ-035 Drop: ch4 pending, wr_ready=0, three more ch4 edges -> drop_count=3, wr_ts keeps first timestamp; 65537 drops -> drop_count=0xFFFF.
REQ-036 Holdoff: holdoff=10, ch2 granted at cycle c; ch2 edges at c+5 (ignored, no count) and c+11 (captured).
REQ-037 Backpressure/enable: wr_ready low 20 cycles -> wr_valid/wr_chan/wr_ts stable throughout; enable=0 edges -> no pending, but prior pending still served.
REQ-038 Reset mid-BUSY with 3 channels pending -> all outputs zero next cycle; a following wr_done produces no state change.
